// File: rtl/ram_arbiter_pkg.sv
// Shared cpu types for the dual-core RAM arbiter.
// RAM status encoding, arbiter FSM states and the default word width.
package ram_arbiter_pkg;

    localparam int WORD_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: ptr names the core that wins a tie.
// Output is one-hot, or zero when nobody requests.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | ~ptr);
        gnt[1] = req[1] & (~req[0] | ptr);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between two cores' instruction and data sides.
// A grant lasts until ACCESS, ERROR or the owner dropping its request.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             iwait,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] iload,
    output logic [1:0][WORD_W-1:0] dload,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    output logic                   ramREN,
    output logic                   ramWEN,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    arb_state_t state, nstate;
    ramstate_t  rs;

    logic       own;
    logic       own_d;
    logic       ptr;
    logic [1:0] dreq;
    logic [1:0] creq;
    logic [1:0] pick;
    logic       pick_core;
    logic       own_act;
    logic       busy;
    logic       done;

    assign rs        = ramstate_t'(ramstate);
    assign dreq      = dREN | dWEN;
    assign creq      = dreq | iREN;
    assign pick_core = pick[1];

    rr_pick2 u_pick (
        .req (creq),
        .ptr (ptr),
        .gnt (pick)
    );

    // Owner still asking for the side it was granted.
    assign own_act = own_d ? dreq[own] : iREN[own];
    assign busy    = (state == GRANT) && own_act && !RST;
    assign done    = busy && (rs == ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            own   <= 1'b0;
            own_d <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= nstate;
            if (state == IDLE && |creq) begin
                own   <= pick_core;
                own_d <= dreq[pick_core];
            end
            if (done) begin
                ptr <= ~own;
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (|creq) begin
                    nstate = GRANT;
                end
            end
            GRANT: begin
                if (!own_act || rs == ACCESS || rs == ERROR) begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;
        if (busy) begin
            if (own_d) begin
                ramaddr    = daddr[own];
                ramWEN     = dWEN[own];
                ramREN     = ~dWEN[own];
                dload[own] = ramload;
                if (dWEN[own]) begin
                    ramstore = dstore[own];
                end
                if (rs == ACCESS) begin
                    dwait[own] = 1'b0;
                end
            end else begin
                ramaddr    = iaddr[own];
                ramREN     = 1'b1;
                iload[own] = ramload;
                if (rs == ACCESS) begin
                    iwait[own] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: single reads, round robin,
// data-over-instruction, ERROR retry, reset mid-grant and abort.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int W = 32;

    logic              CLK;
    logic              RST;
    logic [1:0]        iREN;
    logic [1:0][W-1:0] iaddr;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][W-1:0] daddr;
    logic [1:0][W-1:0] dstore;
    logic [1:0]        iwait;
    logic [1:0]        dwait;
    logic [1:0][W-1:0] iload;
    logic [1:0][W-1:0] dload;
    logic [W-1:0]      ramaddr;
    logic [W-1:0]      ramstore;
    logic              ramREN;
    logic              ramWEN;
    logic [W-1:0]      ramload;
    logic [1:0]        ramstate;

    int vecs = 0;
    int errs = 0;

    ram_arbiter #(.WORD_W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        RST      = 1'b1;
        iREN     = 2'b00;
        iaddr    = '0;
        dREN     = 2'b01;
        dWEN     = 2'b00;
        daddr    = '0;
        daddr[0] = 32'h40;
        dstore   = '0;
        ramload  = 32'hDEADBEEF;
        ramstate = BUSY;

        // reset: outputs quiet, wait mirrors request
        smp();
        chk("rst_dwait", W'(dwait), 32'h1);
        chk("rst_ren", W'(ramREN), 32'h0);
        chk("rst_addr", ramaddr, 32'h0);
        chk("rst_dload", dload[0], 32'h0);

        // core0 data read, 3 BUSY then ACCESS
        nxt();
        RST = 1'b0;
        smp();
        chk("rd_idle_ren", W'(ramREN), 32'h0);
        chk("rd_idle_dwait", W'(dwait), 32'h1);
        for (int k = 0; k < 4; k++) begin
            nxt();
            ramstate = (k == 3) ? ACCESS : BUSY;
            smp();
            chk("rd_ren", W'(ramREN), 32'h1);
            chk("rd_addr", ramaddr, 32'h40);
            chk("rd_dwait", W'(dwait), (k == 3) ? 32'h0 : 32'h1);
            if (k == 3) begin
                chk("rd_dload0", dload[0], 32'hDEADBEEF);
                chk("rd_dload1", dload[1], 32'h0);
                chk("rd_store", ramstore, 32'h0);
            end
        end
        nxt();
        dREN     = 2'b00;
        ramstate = FREE;
        smp();
        chk("rd_after_ren", W'(ramREN), 32'h0);

        // fresh pointer, then both cores fetch continuously
        nxt();
        RST = 1'b1;
        nxt();
        RST      = 1'b0;
        iREN     = 2'b11;
        iaddr[0] = 32'h0;
        iaddr[1] = 32'h200;
        ramstate = ACCESS;
        smp();
        chk("rr_idle_ren", W'(ramREN), 32'h0);
        chk("rr_idle_iwait", W'(iwait), 32'h3);
        for (int k = 1; k <= 5; k++) begin
            nxt();
            smp();
            if (k % 2 == 1) begin
                chk("rr_ren", W'(ramREN), 32'h1);
                chk("rr_addr", ramaddr, (((k - 1) / 2) % 2 == 1) ? 32'h200 : 32'h0);
                chk("rr_iwait", W'(iwait), (((k - 1) / 2) % 2 == 1) ? 32'h1 : 32'h2);
            end else begin
                chk("rr_gap_ren", W'(ramREN), 32'h0);
                chk("rr_gap_iwait", W'(iwait), 32'h3);
            end
        end

        // core1 instruction + data write together: write first
        nxt();
        iREN      = 2'b10;
        dWEN      = 2'b10;
        daddr[1]  = 32'h204;
        dstore[1] = 32'h12345678;
        iaddr[1]  = 32'h300;
        ramload   = 32'hCAFEF00D;
        smp();
        chk("wr_idle_dwait", W'(dwait), 32'h2);
        chk("wr_idle_wen", W'(ramWEN), 32'h0);
        nxt();
        smp();
        chk("wr_wen", W'(ramWEN), 32'h1);
        chk("wr_ren", W'(ramREN), 32'h0);
        chk("wr_store", ramstore, 32'h12345678);
        chk("wr_addr", ramaddr, 32'h204);
        chk("wr_dwait", W'(dwait), 32'h0);
        chk("wr_iwait", W'(iwait), 32'h2);
        nxt();
        dWEN = 2'b00;
        smp();
        chk("wr_gap_ren", W'(ramREN), 32'h0);
        nxt();
        smp();
        chk("if1_ren", W'(ramREN), 32'h1);
        chk("if1_addr", ramaddr, 32'h300);
        chk("if1_store", ramstore, 32'h0);
        chk("if1_iwait", W'(iwait), 32'h0);
        chk("if1_iload", iload[1], 32'hCAFEF00D);

        // core0 read hits ERROR once; core1 also waiting
        nxt();
        iREN     = 2'b10;
        dREN     = 2'b01;
        daddr[0] = 32'h80;
        ramstate = ERROR;
        smp();
        chk("er_idle_dwait", W'(dwait), 32'h1);
        nxt();
        smp();
        chk("er_addr", ramaddr, 32'h80);
        chk("er_dwait", W'(dwait), 32'h1);
        nxt();
        ramstate = ACCESS;
        smp();
        chk("er_gap_dwait", W'(dwait), 32'h1);
        chk("er_gap_ren", W'(ramREN), 32'h0);
        nxt();
        smp();
        chk("er_retry_addr", ramaddr, 32'h80);
        chk("er_retry_dwait", W'(dwait), 32'h0);
        chk("er_retry_iwait", W'(iwait), 32'h2);
        nxt();
        dREN     = 2'b00;
        ramstate = BUSY;
        smp();
        nxt();
        smp();
        chk("c1_addr", ramaddr, 32'h300);
        chk("c1_iwait", W'(iwait), 32'h2);

        // reset in the middle of core1's grant
        nxt();
        iREN     = 2'b11;
        iaddr[0] = 32'h10;
        RST      = 1'b1;
        #1;
        chk("mr_ren", W'(ramREN), 32'h0);
        chk("mr_addr", ramaddr, 32'h0);
        chk("mr_iwait", W'(iwait), 32'h3);
        chk("mr_iload", iload[1], 32'h0);
        nxt();
        RST = 1'b0;
        smp();
        chk("mr_idle_ren", W'(ramREN), 32'h0);
        nxt();
        smp();
        chk("mr_first_addr", ramaddr, 32'h10);
        chk("mr_first_iload0", iload[0], 32'hCAFEF00D);
        chk("mr_first_iload1", iload[1], 32'h0);

        // owner drops its request mid-grant
        nxt();
        iREN = 2'b10;
        smp();
        chk("ab_ren", W'(ramREN), 32'h0);
        chk("ab_addr", ramaddr, 32'h0);
        chk("ab_iwait", W'(iwait), 32'h2);
        nxt();
        smp();
        chk("ab_idle_ren", W'(ramREN), 32'h0);
        nxt();
        smp();
        chk("ab_next_addr", ramaddr, 32'h300);
        chk("ab_next_ren", W'(ramREN), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: WORD_W, 32, width of addresses and data words.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 iREN  in  2  per-core instruction read request (bit n = core n).
REQ-005 iaddr  in  2xWORD_W  per-core instruction address.
REQ-006 dREN  in  2  per-core data read request.
REQ-007 dWEN  in  2  per-core data write request.
REQ-008 daddr  in  2xWORD_W  per-core data address.
REQ-009 dstore  in  2xWORD_W  per-core write data.
REQ-010 iwait  out  2  per-core instruction stall; low = transfer complete this cycle.
REQ-011 dwait  out  2  per-core data stall; low = transfer complete this cycle.
REQ-012 iload  out  2xWORD_W  per-core instruction read data.
REQ-013 dload  out  2xWORD_W  per-core data read data.
REQ-014 ramaddr  out  WORD_W  address to RAM.
REQ-015 ramstore  out  WORD_W  write data to RAM.
REQ-016 ramREN  out  1  RAM read enable.
REQ-017 ramWEN  out  1  RAM write enable.
REQ-018 ramload  in  WORD_W  RAM read data.
REQ-019 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-020 The arbiter SHALL implement FSM states IDLE and GRANT; at most one of the four requesters (core0/core1 x instr/data) SHALL own the RAM at any time.
REQ-021 In IDLE, the arbiter SHALL select a requester combinationally and register the grant, entering GRANT on the next edge; with no request it SHALL remain in IDLE.
REQ-022 Within one core, a data request (dREN|dWEN) SHALL win over iREN.
REQ-023 Between cores, a round-robin pointer SHALL give priority to the core not served last.
REQ-024 The pointer SHALL update only when a transfer completes.
REQ-025 In GRANT, ramaddr/ramstore/ramREN/ramWEN SHALL reflect the owner's current inputs; ramstore SHALL be 0 for reads.
REQ-026 In IDLE, ramREN and ramWEN SHALL be 0.
REQ-027 ramaddr and ramstore SHALL be 0 in IDLE.
REQ-028 dWEN and dREN both high on one core SHALL be treated as a write.
REQ-029 Every wait bit SHALL equal its request bit, except for the owner.
REQ-030 The owner's wait bit SHALL be 0 exactly in the cycle where the FSM is in GRANT and ramstate==ACCESS.
REQ-031 iload/dload of the owner SHALL forward ramload combinationally; all other load outputs SHALL be 0.
REQ-032 On ramstate==ACCESS in GRANT, the FSM SHALL return to IDLE, giving minimum occupancy of 2 cycles per transfer and a 1-cycle IDLE gap between grants.
REQ-033 On ramstate==ERROR in GRANT, the FSM SHALL return to IDLE without lowering wait and without moving the pointer; the request is re-arbitrated.
REQ-034 If the owner drops its request during GRANT, the FSM SHALL abort to IDLE next edge, with RAM enables 0 from the cycle of the drop.
REQ-035 FREE or BUSY in GRANT SHALL hold the grant.

Reset
REQ-036 RST high SHALL force, asynchronously: state=IDLE, no owner, pointer=core0.
REQ-037 RST high SHALL force ram outputs to 0 and all load outputs to 0.
REQ-038 Wait outputs during RST SHALL equal their request inputs.
REQ-039 Reset asserted mid-GRANT SHALL abandon the transfer with no completion indication.

Structure
REQ-040 ramstate_t and arb_state_t enums and WORD_W default SHALL live in the shared cpu types package.
REQ-041 The two-input round-robin selection SHALL be a sub-module, rr_pick2 (inputs: req[2], ptr; output: one-hot gnt[2]).

Verification
REQ-042 Core0 dREN, daddr=0x40, RAM returns ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> ramREN high 4 cycles, dwait[0] low 1 cycle, dload[0]=0xDEADBEEF.
REQ-043 Both cores iREN continuously (iaddr 0x0, 0x200), ACCESS every GRANT cycle -> grants alternate core0, core1, core0..., each completing every 2 cycles.
REQ-044 Core1 iREN and dWEN together (daddr=0x204, dstore=0x12345678) -> data write served first with ramWEN=1, ramstore=0x12345678; instruction read follows.
REQ-045 Core0 read gets ERROR once, then ACCESS -> dwait[0] stays high through ERROR, the request is re-granted to core0 (pointer unchanged), and completes.
REQ-046 RST asserted at a cycle of GRANT -> ramREN/ramWEN 0 the same cycle; after release, the first grant goes to core0.
